// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Function : Lets the fetch port and the data port share one single-port
//            memory. One transaction is in flight at a time, and each port
//            uses a req/ack handshake.
// Options  : Define MEM_ARB_RR_EN to use round-robin arbitration on ties.
//            When it is not defined, the data port always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [2:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_ack,
    output logic        m_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    localparam logic [2:0] C_LAT     = 3'(MEM_LAT);
    localparam logic [2:0] C_OP_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [2:0]  r_op;
    logic        r_owner;
    logic [2:0]  r_cnt;
    logic [31:0] r_if_rdata;
    logic [31:0] r_m_rdata;
    logic        w_any_req;
    logic        w_grant_m;

    assign w_any_req = if_req | m_req;

`ifdef MEM_ARB_RR_EN
    // r_rr_m_next is high when the data port has priority on the next tie.
    logic r_rr_m_next;

    assign w_grant_m = m_req & (~if_req | r_rr_m_next);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rr_m_next <= 1'b1;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_rr_m_next <= ~w_grant_m;
        end
    end
`else
    assign w_grant_m = m_req;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_ack      = 1'b0;
        m_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if_ack      = ~r_owner;
                m_ack       = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The transaction registers drive the memory bus directly, so the bus holds its value outside ISSUE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_op       <= 3'd0;
            r_owner    <= 1'b0;
            r_cnt      <= 3'd0;
            r_if_rdata <= 32'd0;
            r_m_rdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_m;
                        if (w_grant_m) begin
                            r_addr  <= m_addr;
                            r_wdata <= m_wdata;
                            r_we    <= m_we;
                            r_op    <= m_op;
                        end else begin
                            r_addr  <= if_addr;
                            r_wdata <= 32'd0;
                            r_we    <= 1'b0;
                            r_op    <= C_OP_WORD;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= C_LAT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if ((r_cnt == 3'd1) && !r_we) begin
                        if (r_owner) begin
                            r_m_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_op    = r_op;
    assign owner     = r_owner;
    assign if_rdata  = r_if_rdata;
    assign m_rdata   = r_m_rdata;
    assign if_stall  = if_req & ~if_ack;
    assign m_stall   = m_req & ~m_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Function : Directed bench for three mem_arbiter instances with MEM_LAT set
//            to 1, 3 and 7, each attached to a pipelined memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        if_req    [3];
    logic        m_req     [3];
    logic        m_we      [3];
    logic [31:0] if_addr   [3];
    logic [31:0] m_addr    [3];
    logic [31:0] m_wdata   [3];
    logic [2:0]  m_op      [3];
    logic [31:0] mem_rdata [3];
    logic [31:0] if_rdata  [3];
    logic [31:0] m_rdata   [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [2:0]  mem_op    [3];
    logic        if_ack    [3];
    logic        if_stall  [3];
    logic        m_ack     [3];
    logic        m_stall   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic        owner     [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 7);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
        logic [31:0] r_pd [1:7];
        logic [7:1]  r_pv;

        mem_arbiter #(.MEM_LAT(L)) u_dut (
            .clk(clk), .clr(clr),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
            .if_ack(if_ack[g]), .if_stall(if_stall[g]),
            .m_req(m_req[g]), .m_we(m_we[g]), .m_op(m_op[g]), .m_addr(m_addr[g]),
            .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g]), .m_ack(m_ack[g]),
            .m_stall(m_stall[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_op(mem_op[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .owner(owner[g])
        );

        // Read data is only driven on the one cycle it is valid; poison otherwise.
        always @(posedge clk or negedge clr) begin
            if (!clr) r_pv <= '0;
            else      r_pv <= {r_pv[6:1], mem_en[g]};
        end
        always @(posedge clk) begin
            r_pd[1] <= mem_f(mem_addr[g]);
            for (int k = 2; k <= 7; k++) r_pd[k] <= r_pd[k-1];
        end
        assign mem_rdata[g] = r_pv[L] ? r_pd[L] : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on instance g: it checks the issue cycle, the ack latency and the strobe counts.
    task automatic txn(input int g, input bit is_m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] op, input string tag);
        int en_n = 0;
        int we_n = 0;
        int cyc  = 0;
        bit done = 1'b0;
        if (is_m) begin
            m_req[g] = 1'b1; m_we[g] = we; m_addr[g] = addr; m_wdata[g] = wd; m_op[g] = op;
        end else begin
            if_req[g] = 1'b1; if_addr[g] = addr;
        end
        #1;
        chk({tag, " stall_pending"}, is_m ? m_stall[g] : if_stall[g], 32'd1);
        while (!done && cyc < 20) begin
            step();
            cyc++;
            en_n += int'(mem_en[g]);
            we_n += int'(mem_we[g]);
            if (cyc == 1) begin
                chk({tag, " issue_addr"}, mem_addr[g], addr);
                chk({tag, " issue_op"}, {29'd0, mem_op[g]}, {29'd0, op});
                if (is_m && we) chk({tag, " issue_wdata"}, mem_wdata[g], wd);
            end
            done = is_m ? m_ack[g] : if_ack[g];
        end
        chk({tag, " ack_latency"}, cyc, lat_of(g) + 2);
        chk({tag, " en_pulses"}, en_n, 32'd1);
        chk({tag, " we_pulses"}, we_n, {31'd0, we});
        chk({tag, " stall_at_ack"}, is_m ? m_stall[g] : if_stall[g], 32'd0);
        chk({tag, " owner"}, owner[g], {31'd0, is_m});
        if (is_m) m_req[g] = 1'b0;
        else      if_req[g] = 1'b0;
        m_we[g] = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acks;
        int last;
        int m_cyc;
        int if_cyc;
        int cnt;
        bit exp_own;

        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_req[i] = 1'b0; m_req[i] = 1'b0; m_we[i] = 1'b0; m_op[i] = 3'd0;
            if_addr[i] = 32'd0; m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
        end
        step();
        step();
        chk("rst mem_en", mem_en[0], 32'd0);
        chk("rst if_ack", if_ack[0], 32'd0);
        chk("rst m_ack", m_ack[0], 32'd0);
        chk("rst owner", owner[0], 32'd0);
        chk("rst mem_op", {29'd0, mem_op[0]}, 32'd0);
        chk("rst mem_addr", mem_addr[0], 32'd0);
        chk("rst if_rdata", if_rdata[0], 32'd0);
        clr = 1'b1;
        step();

        // Single fetch, latency 1
        txn(0, 1'b0, 1'b0, 32'h40, 32'd0, 3'b010, "fetch");
        chk("fetch rdata", if_rdata[0], 32'h0050_0093);

        // Load, then a store that must leave m_rdata untouched
        txn(0, 1'b1, 1'b0, 32'h300, 32'd0, 3'b010, "mload");
        chk("mload rdata", m_rdata[0], 32'h0300_FCFF);
        txn(0, 1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF, 3'b010, "store");
        chk("store rdata_kept", m_rdata[0], 32'h0300_FCFF);

        // Reset while the latency-3 instance is in WAIT
        if_req[1] = 1'b1; if_addr[1] = 32'h100;
        step(); step(); step();
        clr = 1'b0;
        #1;
        chk("midrst mem_en", mem_en[1], 32'd0);
        chk("midrst if_ack", if_ack[1], 32'd0);
        chk("midrst mem_addr", mem_addr[1], 32'd0);
        chk("midrst m_rdata0", m_rdata[0], 32'd0);
        if_req[1] = 1'b0;
        step();
        clr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt += int'(if_ack[1]) + int'(mem_en[1]);
        end
        chk("midrst quiet", cnt, 32'd0);
        txn(1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b010, "postrst");
        chk("postrst rdata", if_rdata[1], 32'h0100_FEFF);

        // Latency 7
        txn(2, 1'b0, 1'b0, 32'h200, 32'd0, 3'b010, "lat7");
        chk("lat7 rdata", if_rdata[2], 32'h0200_FDFF);

        // Simultaneous requests: M is served first, then IF
        if_req[0] = 1'b1; if_addr[0] = 32'h40;
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h300; m_op[0] = 3'b010;
        cyc = 0; m_cyc = -1; if_cyc = -1;
        while (if_cyc < 0 && cyc < 40) begin
            step();
            cyc++;
            if (m_ack[0]) begin
                m_cyc = cyc;
                chk("tie m_owner", owner[0], 32'd1);
                m_req[0] = 1'b0;
            end
            if (if_ack[0]) if_cyc = cyc;
        end
        if_req[0] = 1'b0;
        chk("tie m_ack_cyc", m_cyc, 32'd3);
        chk("tie if_ack_cyc", if_cyc, 32'd7);
        chk("tie m_rdata", m_rdata[0], 32'h0300_FCFF);
        chk("tie if_rdata", if_rdata[0], 32'h0050_0093);
        step();

        // Both requests held for four grants
        if_req[0] = 1'b1; m_req[0] = 1'b1;
        cyc = 0; acks = 0; last = 0;
        while (acks < 4 && cyc < 60) begin
            step();
            cyc++;
            if (m_ack[0] || if_ack[0]) begin
`ifdef MEM_ARB_RR_EN
                exp_own = (acks % 2) == 0;
`else
                exp_own = 1'b1;
`endif
                chk("hold owner", owner[0], {31'd0, exp_own});
                chk("hold ack_port", m_ack[0], {31'd0, exp_own});
                chk("hold spacing", cyc - last, (acks == 0) ? 32'd3 : 32'd4);
                last = cyc;
                acks++;
            end
        end
        chk("hold acks", acks, 32'd4);
        if_req[0] = 1'b0; m_req[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(mem_en[0]);
        end
        chk("hold quiet", cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
